// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the bridge (master) and apb_slave_mem (slave).
// Clock and reset stay as plain ports on the modules that use this bundle.
interface apb_slave_mem_if #(
  parameter int NUM_SLAVES = 4
);
  logic [NUM_SLAVES-1:0] PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [31:0]           PADDR;
  logic [31:0]           PWDATA;
  logic [31:0]           PRDATA;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB responder: NUM_SLAVES word-addressed banks of DEPTH words, with two-phase protocol checking.
// Define APB_SLV_PROT_CHECK_EN to build the prot_err / err_cnt reporting; otherwise both read as 0.
module apb_slave_mem #(
  parameter int NUM_SLAVES = 4,
  parameter int DEPTH      = 16
) (
  input  logic           HCLK,
  input  logic           HRESET,
  apb_slave_mem_if.slave apb,
  output logic           prot_err,
  output logic [7:0]     err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  function automatic logic multi_hot(input logic [NUM_SLAVES-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      multi = multi | (seen & v[i]);
      seen  = seen | v[i];
    end
    return multi;
  endfunction

  function automatic logic [SW-1:0] onehot_idx(input logic [NUM_SLAVES-1:0] v);
    logic [SW-1:0] idx;
    idx = {SW{1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      idx = idx | ({SW{v[i]}} & SW'(i));
    end
    return idx;
  endfunction

  function automatic logic [AW-1:0] word_of(input logic [31:0] addr);
    return addr[AW+1:2];
  endfunction

  state_e                state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [31:0]           addr_q, addr_d;
  logic                  write_q, write_d;
  logic                  drop_q, drop_d;
  logic [31:0]           prdata_q, prdata_d;
  logic [31:0]           mem_q [NUM_SLAVES][DEPTH];

  logic                  multi_s;
  logic                  match_s;
  logic                  illegal_s;
  logic                  mem_we_s;
  logic [SW-1:0]         rd_bank_s;
  logic [AW-1:0]         rd_word_s;
  logic [SW-1:0]         wr_bank_s;
  logic [AW-1:0]         wr_word_s;

  assign multi_s   = multi_hot(apb.PSELx);
  assign match_s   = (apb.PSELx == sel_q) && (apb.PADDR == addr_q) && (apb.PWRITE == write_q);
  // PENABLE is only legal in the cycle right after a setup that is still held unchanged.
  assign illegal_s = multi_s || (apb.PENABLE && !((state_q == ST_SETUP) && match_s));
  assign rd_bank_s = onehot_idx(apb.PSELx);
  assign rd_word_s = word_of(apb.PADDR);
  assign wr_bank_s = onehot_idx(sel_q);
  assign wr_word_s = word_of(addr_q);

  // Next-state, setup latching, read-data load and write strobe.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    write_d  = write_q;
    drop_d   = drop_q;
    prdata_d = 32'h0000_0000;
    mem_we_s = 1'b0;
    // drop_q marks the remaining cycles of an already-rejected transfer so it is reported once.
    if (illegal_s) begin
      state_d = ST_IDLE;
      drop_d  = 1'b1;
    end else if (apb.PENABLE) begin
      state_d  = ST_ACCESS;
      drop_d   = 1'b0;
      mem_we_s = write_q;
    end else if (|apb.PSELx) begin
      state_d  = ST_SETUP;
      drop_d   = 1'b0;
      sel_d    = apb.PSELx;
      addr_d   = apb.PADDR;
      write_d  = apb.PWRITE;
      prdata_d = apb.PWRITE ? 32'h0000_0000 : mem_q[rd_bank_s][rd_word_s];
    end else begin
      state_d = ST_IDLE;
      drop_d  = 1'b0;
    end
  end

  // Control registers, read-data register and bank storage.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      sel_q    <= {NUM_SLAVES{1'b0}};
      addr_q   <= 32'h0000_0000;
      write_q  <= 1'b0;
      drop_q   <= 1'b0;
      prdata_q <= 32'h0000_0000;
      for (int b = 0; b < NUM_SLAVES; b++) begin
        for (int w = 0; w < DEPTH; w++) begin
          mem_q[b][w] <= 32'h0000_0000;
        end
      end
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      drop_q   <= drop_d;
      prdata_q <= prdata_d;
      if (mem_we_s) begin
        mem_q[wr_bank_s][wr_word_s] <= apb.PWDATA;
      end
    end
  end

  assign apb.PRDATA = prdata_q;

`ifdef APB_SLV_PROT_CHECK_EN
  logic       prot_err_q, prot_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       new_viol_s;

  assign new_viol_s = illegal_s && !drop_q;

  // Sticky flag and saturating violation counter.
  always_comb begin
    prot_err_d = prot_err_q;
    err_cnt_d  = err_cnt_q;
    if (new_viol_s) begin
      prot_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      prot_err_d = prot_err_q;
    end
  end

  // Reporting registers, cleared only by reset.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      prot_err_q <= 1'b0;
      err_cnt_q  <= 8'h00;
    end else begin
      prot_err_q <= prot_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign prot_err = prot_err_q;
  assign err_cnt  = err_cnt_q;
`else
  assign prot_err = 1'b0;
  assign err_cnt  = 8'h00;
`endif

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomized self-checking bench for apb_slave_mem against a transaction-level memory/error model.
module tb_apb_slave_mem;

  localparam int NS = 4;
  localparam int DP = 16;
`ifdef APB_SLV_PROT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       HCLK;
  logic       HRESET;
  logic       prot_err;
  logic [7:0] err_cnt;

  apb_slave_mem_if #(.NUM_SLAVES(NS)) bus ();

  apb_slave_mem #(.NUM_SLAVES(NS), .DEPTH(DP)) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .apb      (bus),
    .prot_err (prot_err),
    .err_cnt  (err_cnt)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int          n_checks = 0;
  int          n_errors = 0;
  int          err_model;
  logic [31:0] model_mem [NS][DP];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int bank_of(input logic [3:0] sel);
    for (int i = 0; i < NS; i++) if (sel[i]) return i;
    return 0;
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) % DP);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NS; b++)
      for (int w = 0; w < DP; w++)
        model_mem[b][w] = 32'h0;
    err_model = 0;
  endtask

  task automatic model_viol();
    if (err_model < 255) err_model++;
  endtask

  task automatic drive(input logic [3:0] sel, input logic en, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.PSELx   = sel;
    bus.PENABLE = en;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = wdata;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_prot_err"}, {31'h0, prot_err}, (CHK && err_model != 0) ? 32'h1 : 32'h0);
    check_eq({tag, "_err_cnt"}, {24'h0, err_cnt}, CHK ? 32'(err_model) : 32'h0);
  endtask

  task automatic go_idle();
    drive(4'b0000, 1'b0, 1'b0, $urandom, $urandom);
    tick();
    check_eq("idle_prdata", bus.PRDATA, 32'h0);
  endtask

  task automatic write_txn(input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] data);
    drive(sel, 1'b0, 1'b1, addr, $urandom);
    tick();
    check_eq("wr_access_prdata", bus.PRDATA, 32'h0);
    drive(sel, 1'b1, 1'b1, addr, data);
    tick();
    model_mem[bank_of(sel)][word_of(addr)] = data;
    check_eq("wr_end_prdata", bus.PRDATA, 32'h0);
  endtask

  task automatic read_txn(input string tag, input logic [3:0] sel, input logic [31:0] addr);
    drive(sel, 1'b0, 1'b0, addr, $urandom);
    tick();
    check_eq(tag, bus.PRDATA, model_mem[bank_of(sel)][word_of(addr)]);
    drive(sel, 1'b1, 1'b0, addr, $urandom);
    tick();
    check_eq("rd_end_prdata", bus.PRDATA, 32'h0);
  endtask

  function automatic logic [3:0] rand_sel();
    logic [3:0] one;
    one = 4'b0001;
    return one << $urandom_range(0, NS - 1);
  endfunction

  // One faulty transfer of the requested kind; always followed by an idle cycle.
  task automatic viol_txn(input int kind);
    logic [3:0]  sel;
    logic [31:0] a1;
    logic [31:0] d;
    int          x;
    int          y;
    sel = rand_sel();
    a1  = $urandom_range(0, 255);
    d   = $urandom;
    case (kind)
      0: begin
        x   = $urandom_range(0, NS - 1);
        y   = (x + $urandom_range(1, NS - 1)) % NS;
        sel = 4'(1 << x) | 4'(1 << y);
        drive(sel, 1'b0, 1'b1, a1, $urandom);
        tick();
        drive(sel, 1'b1, 1'b1, a1, d);
        tick();
      end
      1: begin
        drive(sel, 1'b0, 1'b1, a1, $urandom);
        tick();
        drive(sel, 1'b1, 1'b1, a1 ^ (32'h1 << $urandom_range(0, 31)), d);
        tick();
      end
      2: begin
        drive(sel, 1'b0, 1'b0, a1, $urandom);
        tick();
        drive(sel, 1'b1, 1'b1, a1, d);
        tick();
      end
      3: begin
        write_txn(sel, a1, d);
        drive(sel, 1'b1, 1'b1, a1, ~d);
        tick();
      end
      default: begin
        drive(sel, 1'b1, 1'b1, a1, d);
        tick();
      end
    endcase
    model_viol();
    check_eq("viol_prdata", bus.PRDATA, 32'h0);
    go_idle();
  endtask

  initial begin
    logic [3:0]  sel;
    logic [31:0] addr;
    drive(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();
    HRESET = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
    tick();
    check_eq("reset_prdata", bus.PRDATA, 32'h0);
    check_status("reset");

    // Basic write/read and bank isolation
    write_txn(4'b0010, 32'h8, 32'hDEADBEEF);
    read_txn("rd_deadbeef", 4'b0010, 32'h8);
    read_txn("rd_other_bank", 4'b0001, 32'h8);
    check_eq("rd_other_bank_zero", model_mem[0][2], 32'h0);
    go_idle();

    // Back-to-back write then read of the same word
    write_txn(4'b0100, 32'h4, 32'h1234);
    read_txn("rd_b2b", 4'b0100, 32'h4);
    check_status("b2b");

    // Address aliasing modulo 4*DEPTH bytes
    write_txn(4'b0001, 32'h0, 32'hA5A5A5A5);
    read_txn("rd_alias", 4'b0001, 32'h40);
    go_idle();

    // Multi-hot select reported once, nothing written
    drive(4'b0011, 1'b0, 1'b1, 32'h8, 32'h0);
    tick();
    drive(4'b0011, 1'b1, 1'b1, 32'h8, 32'h55AA55AA);
    tick();
    model_viol();
    go_idle();
    check_status("multi_sel");
    read_txn("multi_b0", 4'b0001, 32'h8);
    read_txn("multi_b1", 4'b0010, 32'h8);
    go_idle();

    // Address changed between setup and access, repeated past saturation
    for (int i = 0; i < 300; i++) begin
      drive(4'b1000, 1'b0, 1'b1, 32'h0, $urandom);
      tick();
      drive(4'b1000, 1'b1, 1'b1, 32'h4, 32'hCAFE0000 + 32'(i));
      tick();
      model_viol();
      if (i == 0) check_status("addr_chg_first");
    end
    go_idle();
    check_status("addr_chg_sat");
    read_txn("addr_chg_w0", 4'b1000, 32'h0);
    read_txn("addr_chg_w1", 4'b1000, 32'h4);
    go_idle();

    // Randomized mix of legal transfers and violations
    for (int i = 0; i < 250; i++) begin
      sel  = rand_sel();
      addr = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      if ($urandom_range(0, 9) == 0) begin
        viol_txn($urandom_range(0, 4));
      end else if ($urandom_range(0, 1) == 0) begin
        write_txn(sel, addr, $urandom);
      end else begin
        read_txn("rand_rd", sel, addr);
      end
      if ($urandom_range(0, 1) == 0) go_idle();
      check_status("rand");
    end
    go_idle();

    // Reset during a read access clears PRDATA at once
    write_txn(4'b0100, 32'h10, 32'h0BADF00D);
    drive(4'b0100, 1'b0, 1'b0, 32'h10, 32'h0);
    tick();
    check_eq("rst_rd_pre", bus.PRDATA, 32'h0BADF00D);
    drive(4'b0100, 1'b1, 1'b0, 32'h10, 32'h0);
    #2 HRESET = 1'b1;
    #1 check_eq("rst_rd_prdata_async", bus.PRDATA, 32'h0);
    model_reset();
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    go_idle();
    check_status("rst_rd");
    read_txn("rst_rd_cleared", 4'b0100, 32'h10);

    // Reset during a write access: nothing committed
    drive(4'b1000, 1'b0, 1'b1, 32'h20, $urandom);
    tick();
    drive(4'b1000, 1'b1, 1'b1, 32'h20, 32'hFFFF);
    #2 HRESET = 1'b1;
    #1 check_eq("rst_wr_prdata_async", bus.PRDATA, 32'h0);
    model_reset();
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    go_idle();
    read_txn("rst_wr_word", 4'b1000, 32'h20);
    check_status("rst_wr");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
